gt_line_fill_ctrl: RTL and testbench

Miss-handling and line-fill controller placed directly downstream of the direct-mapped cache, between the cache and main memory. It accepts one miss at a time, writes the dirty victim line back to memory when required, then fetches the missing 256-bit line as 32-bit beats. The assembled line is returned to the cache on its memData input, together with an explicit fill strobe.

---
 rtl/gt_cache_pkg.sv | 29 ++
 rtl/gt_line_assembler.sv | 48 ++++
 rtl/gt_line_fill_ctrl.sv | 125 ++++++++++++
 tb/tb_gt_line_fill_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gt_cache_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | gt_cache_pkg - shared cache/fill constants, fill-state enum, line align |
// | Rev 1.0                                                                  |
// +------------------------------------------------------------------------+
package gt_cache_pkg;

  localparam int LINE_BITS   = 256;
  localparam int BEAT_BITS   = 32;
  localparam int BEATS       = LINE_BITS / BEAT_BITS;
  localparam int ADDR_BITS   = 32;
  localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
  localparam int CNT_BITS    = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    WB_DATA = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    FILL    = 3'd5
  } fill_state_e;

  function automatic logic [ADDR_BITS-1:0] line_align(input logic [ADDR_BITS-1:0] addr);
    return {addr[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/gt_line_assembler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | gt_line_assembler - beat counter plus line buffer, beat load / select   |
// | Rev 1.0                                                                  |
// +------------------------------------------------------------------------+
module gt_line_assembler
  import gt_cache_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 line_load,
  input  logic [LINE_BITS-1:0] line_in,
  input  logic                 beat_load,
  input  logic [BEAT_BITS-1:0] beat_in,
  input  logic                 beat_adv,
  output logic [CNT_BITS-1:0]  cnt,
  output logic [BEAT_BITS-1:0] beat_out,
  output logic [LINE_BITS-1:0] line_out
);

  logic [BEAT_BITS-1:0] r_beat [BEATS];
  logic [CNT_BITS-1:0]  r_cnt;

  // The counter wraps 7->0 on the final beat, so each phase starts at beat 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
      for (int k = 0; k < BEATS; k++) r_beat[k] <= '0;
    end else if (line_load) begin
      r_cnt <= '0;
      for (int k = 0; k < BEATS; k++) r_beat[k] <= line_in[k*BEAT_BITS +: BEAT_BITS];
    end else if (beat_load) begin
      r_beat[r_cnt] <= beat_in;
      r_cnt         <= r_cnt + 1'b1;
    end else if (beat_adv) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt      = r_cnt;
  assign beat_out = r_beat[r_cnt];

  for (genvar k = 0; k < BEATS; k++) begin : g_pack
    assign line_out[k*BEAT_BITS +: BEAT_BITS] = r_beat[k];
  end

endmodule
`default_nettype wire

// File: rtl/gt_line_fill_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | gt_line_fill_ctrl - miss handler: victim write-back, then line refill   |
// | Rev 1.0                                                                  |
// +------------------------------------------------------------------------+
module gt_line_fill_ctrl
  import gt_cache_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 miss_valid,
  output logic                 miss_ready,
  input  logic [ADDR_BITS-1:0] miss_addr,
  input  logic                 victim_dirty,
  input  logic [ADDR_BITS-1:0] victim_addr,
  input  logic [LINE_BITS-1:0] victim_data,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_write,
  output logic [ADDR_BITS-1:0] mem_req_addr,
  output logic [BEAT_BITS-1:0] mem_wdata,
  output logic                 mem_wdata_valid,
  input  logic                 mem_wdata_ready,
  input  logic [BEAT_BITS-1:0] mem_rdata,
  input  logic                 mem_rdata_valid,
  output logic                 fill_valid,
  output logic [ADDR_BITS-1:0] fill_addr,
  output logic [LINE_BITS-1:0] fill_data,
  output logic                 busy
);

  fill_state_e          r_state, w_next;
  logic [ADDR_BITS-1:0] r_miss_line, r_victim_line;
  logic [CNT_BITS-1:0]  w_cnt;
  logic [BEAT_BITS-1:0] w_beat;
  logic [LINE_BITS-1:0] w_line;
  logic                 w_accept, w_last, w_wbeat, w_rbeat;

  assign w_accept = (r_state == IDLE) && miss_valid;
  assign w_last   = (w_cnt == CNT_BITS'(BEATS - 1));
  assign w_wbeat  = (r_state == WB_DATA) && mem_wdata_ready;
  assign w_rbeat  = (r_state == RD_DATA) && mem_rdata_valid;

  // The victim line shares the buffer with the refill: write-back drains it
  // beat by beat before the read beats overwrite every slot.
  gt_line_assembler u_asm (
    .CLK       (CLK),
    .RST       (RST),
    .line_load (w_accept),
    .line_in   (victim_data),
    .beat_load (w_rbeat),
    .beat_in   (mem_rdata),
    .beat_adv  (w_wbeat),
    .cnt       (w_cnt),
    .beat_out  (w_beat),
    .line_out  (w_line)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_miss_line   <= '0;
      r_victim_line <= '0;
    end else if (w_accept) begin
      r_miss_line   <= line_align(miss_addr);
      r_victim_line <= line_align(victim_addr);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (miss_valid) w_next = victim_dirty ? WB_REQ : RD_REQ;
      WB_REQ:  if (mem_req_ready) w_next = WB_DATA;
      WB_DATA: if (mem_wdata_ready && w_last) w_next = RD_REQ;
      RD_REQ:  if (mem_req_ready) w_next = RD_DATA;
      RD_DATA: if (mem_rdata_valid && w_last) w_next = FILL;
      FILL:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decode from state only; miss_ready is also masked by RST so
  // every output reads zero while reset is held.
  always_comb begin
    miss_ready      = 1'b0;
    mem_req_valid   = 1'b0;
    mem_req_write   = 1'b0;
    mem_req_addr    = '0;
    mem_wdata       = '0;
    mem_wdata_valid = 1'b0;
    fill_valid      = 1'b0;
    fill_addr       = '0;
    fill_data       = '0;
    busy            = (r_state != IDLE);
    case (r_state)
      IDLE:    miss_ready = ~RST;
      WB_REQ:  begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = r_victim_line;
      end
      WB_DATA: begin
        mem_wdata_valid = 1'b1;
        mem_wdata       = w_beat;
      end
      RD_REQ:  begin
        mem_req_valid = 1'b1;
        mem_req_addr  = r_miss_line;
      end
      FILL:    begin
        fill_valid = 1'b1;
        fill_addr  = r_miss_line;
        fill_data  = w_line;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_gt_line_fill_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_gt_line_fill_ctrl - randomized bench with transaction-queue model    |
// | Rev 1.0                                                                  |
// +------------------------------------------------------------------------+
module tb_gt_line_fill_ctrl;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         miss_valid = 1'b0;
  logic [31:0]  miss_addr = '0;
  logic         victim_dirty = 1'b0;
  logic [31:0]  victim_addr = '0;
  logic [255:0] victim_data = '0;
  logic         mem_req_ready = 1'b0;
  logic         mem_wdata_ready = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         mem_rdata_valid = 1'b0;

  logic         miss_ready, mem_req_valid, mem_req_write, mem_wdata_valid;
  logic         fill_valid, busy;
  logic [31:0]  mem_req_addr, mem_wdata, fill_addr;
  logic [255:0] fill_data;

  gt_line_fill_ctrl dut (
    .CLK             (CLK),
    .RST             (RST),
    .miss_valid      (miss_valid),
    .miss_ready      (miss_ready),
    .miss_addr       (miss_addr),
    .victim_dirty    (victim_dirty),
    .victim_addr     (victim_addr),
    .victim_data     (victim_data),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_write   (mem_req_write),
    .mem_req_addr    (mem_req_addr),
    .mem_wdata       (mem_wdata),
    .mem_wdata_valid (mem_wdata_valid),
    .mem_wdata_ready (mem_wdata_ready),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid),
    .fill_valid      (fill_valid),
    .fill_addr       (fill_addr),
    .fill_data       (fill_data),
    .busy            (busy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check256(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: each accepted miss expands into the ordered list of
  // bus events it must produce; the head event defines the expected outputs.
  localparam int K_WREQ = 0, K_WBEAT = 1, K_RREQ = 2, K_RBEAT = 3, K_FILL = 4;
  typedef struct { int kind; logic [31:0] val; } op_t;
  op_t          q[$];
  op_t          h;
  logic [255:0] m_line;
  int           rk = 0;
  int           fill_count = 0;
  int           wbeats = 0;
  logic [5:0]   e_ctl;
  logic [31:0]  e_addr, e_wdata, e_faddr;
  logic [255:0] e_fdata;

  always @(negedge CLK) begin : p_compare
    e_ctl = '0; e_addr = '0; e_wdata = '0; e_faddr = '0; e_fdata = '0;
    if (RST) begin
      q.delete();
    end else begin
      if (mem_wdata_valid && mem_wdata_ready) wbeats++;
      if (q.size() == 0) begin
        e_ctl[5] = 1'b1;
        if (miss_valid) begin
          if (victim_dirty) begin
            q.push_back('{kind: K_WREQ, val: victim_addr & ~32'h1F});
            for (int k = 0; k < 8; k++) q.push_back('{kind: K_WBEAT, val: victim_data[k*32 +: 32]});
          end
          q.push_back('{kind: K_RREQ, val: miss_addr & ~32'h1F});
          for (int k = 0; k < 8; k++) q.push_back('{kind: K_RBEAT, val: 32'h0});
          q.push_back('{kind: K_FILL, val: miss_addr & ~32'h1F});
          m_line = '0;
          rk     = 0;
        end
      end else begin
        h = q[0];
        e_ctl[4] = 1'b1;
        case (h.kind)
          K_WREQ, K_RREQ: begin
            e_ctl[3] = 1'b1;
            e_ctl[2] = (h.kind == K_WREQ);
            e_addr   = h.val;
            if (mem_req_ready) void'(q.pop_front());
          end
          K_WBEAT: begin
            e_ctl[1] = 1'b1;
            e_wdata  = h.val;
            if (mem_wdata_ready) void'(q.pop_front());
          end
          K_RBEAT: if (mem_rdata_valid) begin
            m_line[rk*32 +: 32] = mem_rdata;
            rk++;
            void'(q.pop_front());
          end
          K_FILL: begin
            e_ctl[0] = 1'b1;
            e_faddr  = h.val;
            e_fdata  = m_line;
            void'(q.pop_front());
            fill_count++;
          end
          default: ;
        endcase
      end
    end
    check32("ctl", 32'({miss_ready, busy, mem_req_valid, mem_req_write, mem_wdata_valid, fill_valid}), 32'(e_ctl));
    check32("req_addr", mem_req_addr, e_addr);
    check32("wdata", mem_wdata, e_wdata);
    check32("fill_addr", fill_addr, e_faddr);
    check256("fill_data", fill_data, e_fdata);
  end

  // Memory responder: 0 = driven by hand, 1 = backpressure pattern,
  // 2 = fully random, 3 = always ready with a beat every cycle.
  int mem_mode = 0;
  int req_wait = 0;
  initial forever begin
    @(posedge CLK); #2;
    case (mem_mode)
      1: begin
        req_wait        = mem_req_valid ? req_wait + 1 : 0;
        mem_req_ready   = (req_wait > 5);
        mem_wdata_ready = ~mem_wdata_ready;
        mem_rdata_valid = ($urandom_range(0, 2) == 0);
        mem_rdata       = $urandom;
      end
      2: begin
        mem_req_ready   = ($urandom_range(0, 1) == 0);
        mem_wdata_ready = ($urandom_range(0, 3) != 0);
        mem_rdata_valid = ($urandom_range(0, 1) == 0);
        mem_rdata       = $urandom;
      end
      3: begin
        mem_req_ready   = 1'b1;
        mem_wdata_ready = 1'b1;
        mem_rdata_valid = 1'b1;
        mem_rdata       = $urandom;
      end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic wait_fills(input int target, input int budget, input string name);
    int c;
    c = 0;
    while (fill_count < target && c < budget) begin
      tick();
      c++;
    end
    check32(name, 32'(fill_count), 32'(target));
  endtask

  task automatic send_miss(input logic [31:0] a, input logic d, input logic [31:0] va,
                           input logic [255:0] vd);
    int c;
    c = 0;
    miss_addr = a; victim_dirty = d; victim_addr = va; victim_data = vd;
    miss_valid = 1'b1;
    do begin
      tick();
      c++;
    end while (!busy && c < 50);
    check32("accept", 32'(busy), 32'd1);
    miss_valid = 1'b0;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  initial begin : p_watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [255:0] vline;
  int           wb0, f0, c;
  logic         d;

  initial begin : p_main
    tick(); tick();
    check32("rst_ctl", 32'({miss_ready, busy, mem_req_valid, mem_req_write, mem_wdata_valid, fill_valid}), 32'd0);
    check256("rst_fill", fill_data, 256'd0);
    RST = 1'b0;
    tick();

    // 1: clean miss, back-to-back beats, fixed latency
    mem_req_ready = 1'b1;
    send_miss(32'h0000_1234, 1'b0, 32'h0000_2000, rand_line());
    check32("t1_req", 32'({mem_req_valid, mem_req_write}), 32'h2);
    check32("t1_req_addr", mem_req_addr, 32'h0000_1220);
    for (int k = 0; k < 8; k++) begin
      tick();
      mem_rdata_valid = 1'b1;
      mem_rdata       = 32'h1111_1111 * (k + 1);
    end
    tick();
    mem_rdata_valid = 1'b0;
    check32("t1_fill_valid", 32'(fill_valid), 32'd1);
    check32("t1_fill_addr", fill_addr, 32'h0000_1220);
    check32("t1_fill_lo", fill_data[31:0], 32'h1111_1111);
    check32("t1_fill_hi", fill_data[255:224], 32'h8888_8888);
    tick();
    check256("t1_fill_gone", fill_data, 256'd0);

    // 2: dirty miss, write-back order then refill
    mem_wdata_ready = 1'b1;
    for (int k = 0; k < 8; k++) vline[k*32 +: 32] = 32'hA0 + k;
    send_miss(32'h0000_901C, 1'b1, 32'h0000_4437, vline);
    check32("t2_wreq", 32'({mem_req_valid, mem_req_write}), 32'h3);
    check32("t2_wreq_addr", mem_req_addr, 32'h0000_4420);
    for (int k = 0; k < 8; k++) begin
      tick();
      check32("t2_wdata", mem_wdata_valid ? mem_wdata : 32'hFFFF_FFFF, 32'hA0 + k);
    end
    tick();
    check32("t2_rreq", 32'({mem_req_valid, mem_req_write}), 32'h2);
    check32("t2_rreq_addr", mem_req_addr, 32'h0000_9000);
    mem_mode = 3;
    wait_fills(2, 40, "t2_fills");

    // 3: backpressure on every channel, exact write-beat count
    mem_mode = 1;
    wb0 = wbeats;
    send_miss($urandom, 1'b1, $urandom, rand_line());
    wait_fills(3, 300, "t3_fills");
    check32("t3_wbeats", 32'(wbeats - wb0), 32'd8);

    mem_mode = 2;
    for (int i = 0; i < 25; i++) begin
      wb0 = wbeats;
      f0  = fill_count;
      d   = ($urandom_range(0, 1) == 1);
      send_miss($urandom, d, $urandom, rand_line());
      wait_fills(f0 + 1, 400, "rnd_fills");
      check32("rnd_wbeats", 32'(wbeats - wb0), d ? 32'd8 : 32'd0);
    end

    // 4: reset after three read beats aborts without a fill
    mem_mode = 0;
    mem_req_ready = 1'b1; mem_wdata_ready = 1'b1; mem_rdata_valid = 1'b0;
    f0 = fill_count;
    send_miss(32'h0000_5040, 1'b0, 32'h0000_6000, rand_line());
    for (int k = 0; k < 3; k++) begin
      tick();
      mem_rdata_valid = 1'b1;
      mem_rdata       = $urandom;
    end
    tick();
    mem_rdata_valid = 1'b0;
    #2 RST = 1'b1;
    #1;
    check32("t4_async_ctl", 32'({miss_ready, busy, mem_req_valid, mem_req_write, mem_wdata_valid, fill_valid}), 32'd0);
    check32("t4_async_addr", mem_req_addr | mem_wdata | fill_addr, 32'd0);
    check256("t4_async_fill", fill_data, 256'd0);
    tick(); tick();
    RST = 1'b0;
    tick();
    check32("t4_ready", 32'({miss_ready, busy}), 32'h2);
    check32("t4_nofill", 32'(fill_count), 32'(f0));
    mem_mode = 3;
    send_miss(32'h0000_5040, 1'b0, 32'h0000_6000, rand_line());
    wait_fills(f0 + 1, 40, "t4_fills");

    // 5: miss_valid held through a busy period, stray beats while idle
    f0 = fill_count;
    miss_addr = 32'h0000_7000; victim_dirty = 1'b0; miss_valid = 1'b1;
    c = 0;
    do begin tick(); c++; end while (!busy && c < 20);
    miss_addr = 32'h0000_A0C4;
    c = 0;
    while (!fill_valid && c < 40) begin tick(); c++; end
    check32("t5_fill_seen", 32'(fill_valid), 32'd1);
    check32("t5_ready_in_fill", 32'(miss_ready), 32'd0);
    tick();
    check32("t5_ready_after", 32'({miss_ready, busy}), 32'h2);
    tick();
    miss_valid = 1'b0;
    check32("t5_second_req", 32'({busy, mem_req_valid, mem_req_write}), 32'h6);
    check32("t5_second_addr", mem_req_addr, 32'h0000_A0C0);
    wait_fills(f0 + 2, 40, "t5_fills");

    mem_mode = 0;
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
